// File: rtl/e_md_unit_if.sv
// Execute-stage multiply/divide unit port bundle: operation request in, MD data word and status out.
interface e_md_unit_if;
    logic        E_Req;
    logic [3:0]  E_MDOp;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic [31:0] E_MDOut;
    logic        E_Busy;
    logic        E_Start;

    modport master (
        output E_Req, E_MDOp, E_A, E_B,
        input  E_MDOut, E_Busy, E_Start
    );

    modport slave (
        input  E_Req, E_MDOp, E_A, E_B,
        output E_MDOut, E_Busy, E_Start
    );
endinterface

// File: rtl/e_md_unit.sv
// Execute-stage HI/LO multiply/divide unit: result is computed at the start edge,
// held in pending registers, and committed to HI/LO after a fixed busy period.
module e_md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    e_md_unit_if.slave   md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   phi_q, phi_d;
    logic [31:0]   plo_q, plo_d;
    logic          pvalid_q, pvalid_d;

    logic          busy_s;
    logic          op_md_s;
    logic          start_s;
    logic          is_mul_s;
    logic [31:0]   res_hi_s;
    logic [31:0]   res_lo_s;
    logic          res_ok_s;

    logic [63:0]   a_ext_s, b_ext_s, prod_s;
    logic          a_neg_s, b_neg_s;
    logic [31:0]   a_mag_s, b_mag_s, b_safe_s;
    logic [31:0]   quo_u_s, rem_u_s;
    logic [31:0]   quo_s, rem_s;

    assign busy_s   = (state_q == S_BUSY);
    assign op_md_s  = (md.E_MDOp >= OP_MULT) && (md.E_MDOp <= OP_DIVU);
    assign start_s  = op_md_s && !md.E_Req && !busy_s;
    assign is_mul_s = (md.E_MDOp == OP_MULT) || (md.E_MDOp == OP_MULTU);

    // Operand conditioning: sign extension for the multiplier, magnitudes for the divider
    always_comb begin
        a_ext_s = {{32{md.E_A[31] & (md.E_MDOp == OP_MULT)}}, md.E_A};
        b_ext_s = {{32{md.E_B[31] & (md.E_MDOp == OP_MULT)}}, md.E_B};
        prod_s  = a_ext_s * b_ext_s;

        a_neg_s  = md.E_A[31] & (md.E_MDOp == OP_DIV);
        b_neg_s  = md.E_B[31] & (md.E_MDOp == OP_DIV);
        a_mag_s  = a_neg_s ? (32'd0 - md.E_A) : md.E_A;
        b_mag_s  = b_neg_s ? (32'd0 - md.E_B) : md.E_B;
        // A zero divisor never commits, so any non-zero stand-in keeps the divider defined
        b_safe_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
        quo_u_s  = a_mag_s / b_safe_s;
        rem_u_s  = a_mag_s % b_safe_s;
        // -2^31 / -1 falls out naturally: magnitude 0x80000000 negates to itself
        quo_s    = (a_neg_s ^ b_neg_s) ? (32'd0 - quo_u_s) : quo_u_s;
        rem_s    = a_neg_s ? (32'd0 - rem_u_s) : rem_u_s;
    end

    // Result selection per accepted operation
    always_comb begin
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
        res_ok_s = 1'b0;
        case (md.E_MDOp)
            OP_MULT, OP_MULTU: begin
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
                res_ok_s = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                res_hi_s = rem_s;
                res_lo_s = quo_s;
                res_ok_s = (md.E_B != 32'd0);
            end
            default: begin
                res_hi_s = 32'd0;
                res_lo_s = 32'd0;
                res_ok_s = 1'b0;
            end
        endcase
    end

    // Next-state logic: start/MT writes from IDLE, countdown and commit from BUSY
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        phi_d    = phi_q;
        plo_d    = plo_q;
        pvalid_d = pvalid_q;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    phi_d    = res_hi_s;
                    plo_d    = res_lo_s;
                    pvalid_d = res_ok_s;
                    cnt_d    = is_mul_s ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    state_d  = S_BUSY;
                end else if (!md.E_Req && (md.E_MDOp == OP_MTHI)) begin
                    hi_d = md.E_A;
                end else if (!md.E_Req && (md.E_MDOp == OP_MTLO)) begin
                    lo_d = md.E_A;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_q == CW'(1)) begin
                    if (pvalid_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                    cnt_d    = {CW{1'b0}};
                    pvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                cnt_d    = {CW{1'b0}};
                pvalid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            phi_q    <= 32'd0;
            plo_q    <= 32'd0;
            pvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            phi_q    <= phi_d;
            plo_q    <= plo_d;
            pvalid_q <= pvalid_d;
        end
    end

    // MD read port from committed HI/LO
    always_comb begin
        case (md.E_MDOp)
            OP_MFHI: md.E_MDOut = hi_q;
            OP_MFLO: md.E_MDOut = lo_q;
            default: md.E_MDOut = 32'd0;
        endcase
    end

    assign md.E_Busy  = busy_s;
    assign md.E_Start = start_s;

endmodule
